// File: rtl/async_fifo_rd_stream.sv
// Read-side drain stage for the async FIFO: pops via rinc/rempty/rdata and re-presents words as a
// registered valid/ready stream through a two-entry skid buffer. Stats counters: ASYNC_FIFO_RD_STATS_EN.
module async_fifo_rd_stream #(
    parameter int DSIZE = 8
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DSIZE-1:0] m_data,
    output logic [1:0]       level,
    output logic [15:0]      word_cnt,
    output logic [15:0]      stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    occ_e             state_q;
    logic [DSIZE-1:0] head_q;
    logic [DSIZE-1:0] tail_q;
    logic             pop;

    // The pop request looks only at registered occupancy, so m_ready never reaches rinc.
    assign rinc    = rrst_n & ~rempty & (state_q != TWO);
    assign m_valid = (state_q != EMPTY);
    assign pop     = m_valid & m_ready;
    assign m_data  = head_q;
    assign level   = state_q;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (rinc) begin
                        head_q  <= rdata;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    if (rinc && pop) begin
                        head_q <= rdata;
                    end else if (rinc) begin
                        tail_q  <= rdata;
                        state_q <= TWO;
                    end else if (pop) begin
                        state_q <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        head_q  <= tail_q;
                        state_q <= ONE;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

`ifdef ASYNC_FIFO_RD_STATS_EN
    logic [15:0] word_cnt_q;
    logic [15:0] stall_cnt_q;

    // Both counters saturate rather than wrap so long stalls stay visible.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            word_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (pop && (word_cnt_q != 16'hFFFF)) begin
                word_cnt_q <= word_cnt_q + 16'd1;
            end
            if (m_valid && !m_ready && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign word_cnt  = word_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    assign word_cnt  = 16'h0000;
    assign stall_cnt = 16'h0000;
`endif

endmodule
